// File: rtl/seg7_scan_display_if.sv
// Pin bundle between the value source and the scanned 8-digit seven-segment display.
// master drives the value/freeze side; slave is the display driver.
interface seg7_scan_display_if;
   logic [31:0] inVal;
   logic        freeze;
   logic [7:0]  anode;
   logic [6:0]  seg;
   logic        dp;

   modport master (output inVal, output freeze, input anode, input seg, input dp);
   modport slave  (input inVal, input freeze, output anode, output seg, output dp);
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display driver with one coherent snapshot per scan frame.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module seg7_scan_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_display_if.slave bus
);
   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   logic [CNT_W-1:0] presc;
   logic [2:0]       digit;
   logic [31:0]      snap;
   logic             tick;
   logic [3:0]       nibble;
   logic             blank;
   logic [7:0]       anodeNext;
   logic [6:0]       segNext;
   logic [7:0]       anodeR;
   logic [6:0]       segR;

   assign tick = (presc == PRESC_LAST);

   // Capture only on the wrap tick so a frame never mixes two samples of inVal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         digit <= 3'd0;
         snap  <= 32'h0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            digit <= digit + 3'd1;
            if (digit == 3'd7 && !bus.freeze)
               snap <= bus.inVal;
         end
      end
   end

   always_comb begin
      nibble = snap[{digit, 2'b00} +: 4];
      blank  = 1'b0;
`ifdef LZ_BLANK_EN
      blank  = (digit != 3'd0) && ((snap >> {digit, 2'b00}) == 32'h0);
`endif
      anodeNext = blank ? 8'hFF : ~(8'b1 << digit);
      segNext   = blank ? 7'h7F : hex7(nibble);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anodeR <= 8'hFF;
         segR   <= 7'h7F;
      end else begin
         anodeR <= anodeNext;
         segR   <= segNext;
      end
   end

   assign bus.anode = anodeR;
   assign bus.seg   = segR;
   assign bus.dp    = 1'b1;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: per-frame expectations are queued as the
// captured value is decided, then popped slot by slot while the scan is observed.
module tb_seg7_scan_display;
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic incMode;
   logic [7:0]  expAn  [$];
   logic [6:0]  expSeg [$];
   logic [31:0] w1, w2, wx;

   seg7_scan_display_if bus ();

   seg7_scan_display #(.REFRESH_DIV(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected anode/seg for each digit slot of a frame that shows v.
   task automatic pushFrame(input logic [31:0] v);
      logic [7:0] an;
      logic [6:0] sg;
      for (int k = 0; k < 8; k++) begin
         an = ~(8'b1 << k);
         sg = HEX[v[4*k +: 4]];
`ifdef LZ_BLANK_EN
         if (k != 0 && (v >> (4*k)) == 32'h0) begin
            an = 8'hFF;
            sg = 7'h7F;
         end
`endif
         expAn.push_back(an);
         expSeg.push_back(sg);
      end
   endtask

   // Observes one full frame (32 clocks); returns the inVal present at the closing wrap edge.
   task automatic runFrame(input string tag, output logic [31:0] wrapVal);
      logic [7:0] an;
      logic [6:0] sg;
      wrapVal = bus.inVal;
      for (int k = 0; k < 8; k++) begin
         if (expAn.size() == 0) begin
            chk($sformatf("%s queue_empty", tag), 32'd0, 32'd1);
            an = 8'hxx;
            sg = 7'hxx;
         end else begin
            an = expAn.pop_front();
            sg = expSeg.pop_front();
         end
         for (int c = 0; c < 4; c++) begin
            if (k == 7 && c == 3) wrapVal = bus.inVal;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s d%0d c%0d anode", tag, k, c), {24'h0, bus.anode}, {24'h0, an});
            chk($sformatf("%s d%0d c%0d seg", tag, k, c), {25'h0, bus.seg}, {25'h0, sg});
            chk($sformatf("%s d%0d c%0d dp", tag, k, c), {31'h0, bus.dp}, 32'd1);
            if (incMode) bus.inVal = bus.inVal + 32'd1;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      incMode = 1'b0;
      bus.inVal = 32'h0;
      bus.freeze = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset anode", {24'h0, bus.anode}, 32'hFF);
      chk("reset seg", {25'h0, bus.seg}, 32'h7F);
      chk("reset dp", {31'h0, bus.dp}, 32'd1);

      // First frame must show zeros even though inVal is already non-zero.
      bus.inVal = 32'h89ABCDEF;
      rst = 1'b0;
      pushFrame(32'h0);
      runFrame("frame0", wx);

      pushFrame(32'h89ABCDEF);
      bus.inVal = 32'h00000012;
      runFrame("capture", wx);

      pushFrame(32'h00000012);
      bus.freeze = 1'b1;
      bus.inVal = 32'hFFFFFFFF;
      runFrame("frzS", wx);
      for (int i = 0; i < 3; i++) begin
         pushFrame(32'h00000012);
         if (i == 2) bus.freeze = 1'b0;
         runFrame($sformatf("frz%0d", i), wx);
      end

      pushFrame(32'hFFFFFFFF);
      incMode = 1'b1;
      bus.inVal = 32'h12345670;
      runFrame("unfrz", w1);
      pushFrame(w1);
      runFrame("coh1", w2);
      pushFrame(w2);
      incMode = 1'b0;
      bus.inVal = 32'hDEADBEEF;
      runFrame("coh2", wx);

      // Reset asserted while digit 5 is lit.
      repeat (21) @(posedge clk);
      @(negedge clk);
      chk("premid anode", {24'h0, bus.anode}, 32'hDF);
      rst = 1'b1;
      #1;
      chk("midrst anode", {24'h0, bus.anode}, 32'hFF);
      chk("midrst seg", {25'h0, bus.seg}, 32'h7F);
      chk("midrst dp", {31'h0, bus.dp}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst hold anode", {24'h0, bus.anode}, 32'hFF);
      bus.inVal = 32'h00000A05;
      rst = 1'b0;
      pushFrame(32'h0);
      runFrame("rstrun", wx);

      pushFrame(32'h00000A05);
      bus.inVal = 32'h0;
      runFrame("lzA05", wx);
      pushFrame(32'h0);
      runFrame("lz0", wx);

      chk("queue drained", expAn.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
